// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   INSTR_W          : instruction word width
//   ZERO_WORD        : fetch word that marks unused (zero-filled) memory
//   DEFAULT_RESET_PC : byte address the program counter starts from
//   fetch_state_t    : fetch FSM states (RUN / HALT)
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'd100;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register.
// Holds the fetched instruction, its byte address and that address + 4.
//   clk, reset          : clock, asynchronous active-high reset (clears everything)
//   load                : capture instr_d / pc_d / pc_plus4_d and mark the entry valid
//   flush               : drop the entry (valid and instruction cleared); wins over load
//   instr_d, pc_d,
//   pc_plus4_d          : values presented by the fetch stage
//   instruction, pc,
//   pc_plus4, valid     : registered IF/ID contents
// With neither load nor flush the register holds (stall / halt).
module ifid_register
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [31:0]        pc_d,
  input  logic [31:0]        pc_plus4_d,
  output logic [INSTR_W-1:0] instruction,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               valid
);

  logic [INSTR_W-1:0] instr_p1;
  logic [31:0]        pc_p1;
  logic [31:0]        pc_plus4_p1;
  logic               vld_p1;

  // ---- IF -> ID boundary ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_p1    <= ZERO_WORD;
      pc_p1       <= 32'd0;
      pc_plus4_p1 <= 32'd0;
      vld_p1      <= 1'b0;
    end else if (flush) begin
      // Address fields are left alone: only valid/instruction matter downstream.
      instr_p1 <= ZERO_WORD;
      vld_p1   <= 1'b0;
    end else if (load) begin
      instr_p1    <= instr_d;
      pc_p1       <= pc_d;
      pc_plus4_p1 <= pc_plus4_d;
      vld_p1      <= 1'b1;
    end
  end

  assign instruction = instr_p1;
  assign pc          = pc_p1;
  assign pc_plus4    = pc_plus4_p1;
  assign valid       = vld_p1;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage sitting in front of instructionMemory.
// Owns the PC, drives the memory byte address combinationally and captures
// the returned word into the IF/ID register one clock later.
//   clk, reset        : clock, asynchronous active-high reset
//   stall             : hold PC and IF/ID (ignored while halted)
//   redirect          : load PC from redirect_pc and flush IF/ID (beats stall)
//   redirect_pc       : redirect target byte address (wrapped, low 2 bits dropped)
//   imem_instruction  : word read from instruction memory at imem_pc
//   imem_pc           : byte address to instruction memory
//   ifid_instruction, ifid_pc, ifid_pc_plus4, ifid_valid : IF/ID contents
//   halted            : fetch stopped on an all-zero word
//   misaligned        : sticky, some redirect target had nonzero bits [1:0]
//   fetch_count       : valid instructions captured, saturating
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int          ADDR_BITS    = 14,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic [31:0]        imem_pc,
  output logic [INSTR_W-1:0] ifid_instruction,
  output logic [31:0]        ifid_pc,
  output logic [31:0]        ifid_pc_plus4,
  output logic               ifid_valid,
  output logic               halted,
  output logic               misaligned,
  output logic [31:0]        fetch_count
);

  localparam logic [ADDR_BITS-1:0] PC_STEP = ADDR_BITS'(4);

  // The PC only exists inside the memory window, so increments and
  // redirects wrap at 2^ADDR_BITS for free.
  logic [ADDR_BITS-1:0] pc_q;
  logic [ADDR_BITS-1:0] pc_d;
  fetch_state_t         state_q;
  fetch_state_t         state_d;
  logic                 zero_word;
  logic                 load;
  logic                 flush;
  logic                 count_en;
  logic [31:0]          fetch_count_q;
  logic                 misaligned_q;
  logic                 unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[31:ADDR_BITS];

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign imem_pc   = {{(32-ADDR_BITS){1'b0}}, pc_q};
  assign zero_word = HALT_ON_ZERO && (imem_instruction == ZERO_WORD);

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (redirect)                                    state_d = RUN;
    else if (state_q == RUN && !stall && zero_word)  state_d = HALT;
  end

  // FSM: outputs / datapath controls (redirect > halt > stall > normal)
  always_comb begin
    pc_d     = pc_q;
    load     = 1'b0;
    flush    = 1'b0;
    count_en = 1'b0;
    if (redirect) begin
      pc_d  = {redirect_pc[ADDR_BITS-1:2], 2'b00};
      flush = 1'b1;
    end else if (state_q == RUN && !stall) begin
      if (zero_word) begin
        // PC stays parked on the zero word so a later look shows where fetch stopped.
        flush = 1'b1;
      end else begin
        pc_d     = pc_q + PC_STEP;
        load     = 1'b1;
        count_en = 1'b1;
      end
    end
  end

  assign halted = (state_q == HALT);

  // ---- PC / status registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC[ADDR_BITS-1:0];
      fetch_count_q <= 32'd0;
      misaligned_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (count_en)                          fetch_count_q <= sat_inc32(fetch_count_q);
      if (redirect && (redirect_pc[1:0] != 2'b00)) misaligned_q <= 1'b1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign misaligned  = misaligned_q;

  ifid_register u_ifid (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .flush       (flush),
    .instr_d     (imem_instruction),
    .pc_d        (imem_pc),
    .pc_plus4_d  (imem_pc + 32'd4),
    .instruction (ifid_instruction),
    .pc          (ifid_pc),
    .pc_plus4    (ifid_pc_plus4),
    .valid       (ifid_valid)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: one HALT_ON_ZERO=1 and one HALT_ON_ZERO=0
// instance share a word-addressed memory; a behavioural model of each fetch
// stage is stepped on every clock and compared on every falling edge, with
// hand-computed literal checks along the directed scenarios.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_s       [2];
  logic        redirect_s    [2];
  logic [31:0] redirect_pc_s [2];
  logic [31:0] imem_w        [2];
  logic [31:0] imem_pc_s     [2];
  logic [31:0] instr_s       [2];
  logic [31:0] ipc_s         [2];
  logic [31:0] ipc4_s        [2];
  logic        vld_s         [2];
  logic        halted_s      [2];
  logic        mis_s         [2];
  logic [31:0] cnt_s         [2];

  logic [31:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_w[0] = mem[imem_pc_s[0][13:2]];
  assign imem_w[1] = mem[imem_pc_s[1][13:2]];

  instruction_fetch_unit #(.RESET_PC(32'd100), .ADDR_BITS(14), .HALT_ON_ZERO(1'b1)) dut0 (
    .clk(clk), .reset(reset), .stall(stall_s[0]), .redirect(redirect_s[0]),
    .redirect_pc(redirect_pc_s[0]), .imem_instruction(imem_w[0]), .imem_pc(imem_pc_s[0]),
    .ifid_instruction(instr_s[0]), .ifid_pc(ipc_s[0]), .ifid_pc_plus4(ipc4_s[0]),
    .ifid_valid(vld_s[0]), .halted(halted_s[0]), .misaligned(mis_s[0]), .fetch_count(cnt_s[0])
  );

  instruction_fetch_unit #(.RESET_PC(32'd100), .ADDR_BITS(14), .HALT_ON_ZERO(1'b0)) dut1 (
    .clk(clk), .reset(reset), .stall(stall_s[1]), .redirect(redirect_s[1]),
    .redirect_pc(redirect_pc_s[1]), .imem_instruction(imem_w[1]), .imem_pc(imem_pc_s[1]),
    .ifid_instruction(instr_s[1]), .ifid_pc(ipc_s[1]), .ifid_pc_plus4(ipc4_s[1]),
    .ifid_valid(vld_s[1]), .halted(halted_s[1]), .misaligned(mis_s[1]), .fetch_count(cnt_s[1])
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic [31:0] cnt;
    logic        vld;
    logic        halted;
    logic        mis;
  } mdl_t;

  mdl_t m [2];

  task automatic mreset(input int k);
    m[k].pc = 32'd100; m[k].instr = 0; m[k].ipc = 0; m[k].ipc4 = 0;
    m[k].cnt = 0; m[k].vld = 0; m[k].halted = 0; m[k].mis = 0;
  endtask

  task automatic mstep(input int k);
    logic [31:0] word;
    word = mem[m[k].pc[13:2]];
    if (redirect_s[k]) begin
      m[k].pc     = (redirect_pc_s[k] % 32'd16384) & ~32'd3;
      m[k].vld    = 0;
      m[k].instr  = 0;
      m[k].halted = 0;
      if (redirect_pc_s[k][1:0] != 2'b00) m[k].mis = 1;
    end else if (m[k].halted || stall_s[k]) begin
      // nothing moves
    end else if (k == 0 && word == 32'h0) begin
      m[k].vld    = 0;
      m[k].instr  = 0;
      m[k].halted = 1;
    end else begin
      m[k].instr = word;
      m[k].ipc   = m[k].pc;
      m[k].ipc4  = m[k].pc + 4;
      m[k].vld   = 1;
      if (m[k].cnt != 32'hFFFF_FFFF) m[k].cnt = m[k].cnt + 1;
      m[k].pc    = (m[k].pc + 4) % 32'd16384;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mreset(0);
      mreset(1);
    end else begin
      mstep(0);
      mstep(1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        string p;
        p = (k == 0) ? "hoz1" : "hoz0";
        chk({p, ".imem_pc"},          imem_pc_s[k],     m[k].pc);
        chk({p, ".ifid_instruction"}, instr_s[k],       m[k].instr);
        chk({p, ".ifid_valid"},       32'(vld_s[k]),    32'(m[k].vld));
        chk({p, ".halted"},           32'(halted_s[k]), 32'(m[k].halted));
        chk({p, ".misaligned"},       32'(mis_s[k]),    32'(m[k].mis));
        chk({p, ".fetch_count"},      cnt_s[k],         m[k].cnt);
        if (m[k].vld) begin
          chk({p, ".ifid_pc"},       ipc_s[k],  m[k].ipc);
          chk({p, ".ifid_pc_plus4"}, ipc4_s[k], m[k].ipc4);
        end
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic redir(input int k, input logic [31:0] target, input logic st);
    redirect_s[k] = 1'b1; redirect_pc_s[k] = target; stall_s[k] = st;
    tick();
    redirect_s[k] = 1'b0; stall_s[k] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      stall_s[k] = 0; redirect_s[k] = 0; redirect_pc_s[k] = 0;
    end
    for (int i = 0; i < 4096; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
    for (int i = 0; i < 8; i++)
      mem[25 + i] = 32'h4808_0000 + (i << 16) + 4 * i;
    mem[33]   = 32'h0;
    mem[50]   = 32'h2413_0005;
    mem[128]  = 32'h1674_FFFB;
    mem[4095] = 32'h0;

    repeat (2) tick();
    reset = 1'b0;
    chk("t1.reset_imem_pc", imem_pc_s[0], 32'd100);
    chk("t1.reset_valid",   32'(vld_s[0]), 32'd0);

    // 1: straight-line fetch into the zero word
    tick();
    chk("t1.e1_instr", instr_s[0], 32'h4808_0000);
    chk("t1.e1_pc",    ipc_s[0],   32'd100);
    chk("t1.e1_valid", 32'(vld_s[0]), 32'd1);
    repeat (7) tick();
    chk("t1.e8_pc",    ipc_s[0],   32'd128);
    chk("t1.e8_instr", instr_s[0], 32'h480F_001C);
    tick();
    chk("t1.e9_halted",  32'(halted_s[0]), 32'd1);
    chk("t1.e9_valid",   32'(vld_s[0]),    32'd0);
    chk("t1.e9_imem_pc", imem_pc_s[0],     32'd132);
    chk("t1.e9_count",   cnt_s[0],         32'd8);

    // 2: stall while imem_pc=108
    redir(0, 32'd100, 1'b0);
    repeat (2) tick();
    chk("t2.imem_pc", imem_pc_s[0], 32'd108);
    stall_s[0] = 1'b1;
    repeat (3) tick();
    stall_s[0] = 1'b0;
    chk("t2.stall_imem_pc", imem_pc_s[0],  32'd108);
    chk("t2.stall_instr",   instr_s[0],    32'h4809_0004);
    chk("t2.stall_valid",   32'(vld_s[0]), 32'd1);
    chk("t2.stall_count",   cnt_s[0],      32'd10);
    tick();
    chk("t2.release_instr", instr_s[0], 32'h480A_0008);
    repeat (6) tick();
    chk("t2.halted_again", 32'(halted_s[0]), 32'd1);

    // 3: redirect out of HALT
    redir(0, 32'd200, 1'b0);
    chk("t3.imem_pc", imem_pc_s[0],     32'd200);
    chk("t3.halted",  32'(halted_s[0]), 32'd0);
    chk("t3.valid",   32'(vld_s[0]),    32'd0);
    tick();
    chk("t3.instr", instr_s[0], 32'h2413_0005);
    chk("t3.pc",    ipc_s[0],   32'd200);
    chk("t3.pc4",   ipc4_s[0],  32'd204);

    // 4: redirect beats a simultaneous stall
    redir(0, 32'd512, 1'b0);
    tick();
    chk("t4.imem_pc", imem_pc_s[0], 32'd516);
    chk("t4.instr",   instr_s[0],   32'h1674_FFFB);
    redir(0, 32'd500, 1'b1);
    chk("t4.redir_pc",    imem_pc_s[0],  32'd500);
    chk("t4.redir_valid", 32'(vld_s[0]), 32'd0);

    // 5: misaligned and out-of-range targets
    redir(0, 32'h202, 1'b0);
    chk("t5.imem_pc", imem_pc_s[0],  32'h200);
    chk("t5.mis",     32'(mis_s[0]), 32'd1);
    redir(0, 32'h100, 1'b0);
    chk("t5.mis_sticky", 32'(mis_s[0]), 32'd1);
    redir(0, 32'h4258, 1'b0);
    chk("t5.wrap_pc", imem_pc_s[0], 32'd600);

    // 6: HALT_ON_ZERO=0 passes the zero word and wraps; async reset
    redir(1, 32'd16380, 1'b0);
    tick();
    chk("t6.wrap_pc",   imem_pc_s[1],  32'd0);
    chk("t6.valid",     32'(vld_s[1]), 32'd1);
    chk("t6.instr",     instr_s[1],    32'h0);
    chk("t6.pc4",       ipc4_s[1],     32'd16384);
    #2;
    reset = 1'b1;
    #1;
    chk("t6.rst_imem_pc", imem_pc_s[1],  32'd100);
    chk("t6.rst_valid",   32'(vld_s[1]), 32'd0);
    chk("t6.rst_count",   cnt_s[1],      32'd0);
    chk("t6.rst_mis0",    32'(mis_s[0]), 32'd0);
    chk("t6.rst_instr",   instr_s[1],    32'd0);
    tick();
    reset = 1'b0;

    // randomized phase, model-checked every cycle
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 2; k++) begin
        int r;
        stall_s[k]    = ($urandom_range(0, 3) == 0);
        redirect_s[k] = ($urandom_range(0, 9) == 0);
        r = $urandom_range(0, 3);
        if (r == 0)      redirect_pc_s[k] = $urandom();
        else if (r == 1) redirect_pc_s[k] = 32'd16368 + 32'($urandom_range(0, 15));
        else             redirect_pc_s[k] = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      end
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
